// File: rtl/reg_file_pkg.sv
// Shared widths, zero-register index and data/address types for the register file.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array select, x0 forced to zero, optional forwarding.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              reset,
  input  logic              wrt_en,
  input  logic [ADDR_W-1:0] wrt_addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

`ifdef REGFILE_BYPASS_EN
  logic fwd;
  assign fwd = wrt_en && !reset && (wrt_addr != ZERO_ADDR) && (wrt_addr == rd_addr);
`else
  logic unused_ok;
  assign unused_ok = ^{reset, wrt_en, wrt_addr, wrt_data};
`endif

  always_comb begin
    rd_data = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (fwd) rd_data = wrt_data;
`endif
    // x0 is hard-wired, so it wins over both storage and forwarding
    if (rd_addr == ZERO_ADDR) rd_data = '0;
  end

endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write register file with hard-wired zero register and sync reset.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [0:DEPTH-1];

  // Reset has priority; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (rg_wrt_en && (rg_wrt_addr != ZERO_ADDR)) begin
      regs[rg_wrt_addr] <= rg_wrt_data;
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
    .regs     (regs),
    .rd_addr  (rg_rd_addr1),
    .reset    (reset),
    .wrt_en   (rg_wrt_en),
    .wrt_addr (rg_wrt_addr),
    .wrt_data (rg_wrt_data),
    .rd_data  (rg_rd_data1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
    .regs     (regs),
    .rd_addr  (rg_rd_addr2),
    .reset    (reset),
    .wrt_en   (rg_wrt_en),
    .wrt_addr (rg_wrt_addr),
    .wrt_data (rg_wrt_data),
    .rd_data  (rg_rd_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;
  import reg_file_pkg::*;

  logic  clk = 1'b0;
  logic  reset, wen;
  addr_t waddr, ra1, ra2;
  data_t wdata, rd1, rd2;

  int nvec  = 0;
  int nfail = 0;

  reg_file dut (
    .clk         (clk),
    .reset       (reset),
    .rg_wrt_en   (wen),
    .rg_wrt_addr (waddr),
    .rg_wrt_data (wdata),
    .rg_rd_addr1 (ra1),
    .rg_rd_addr2 (ra2),
    .rg_rd_data1 (rd1),
    .rg_rd_data2 (rd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  reset;
    logic  wen;
    addr_t waddr;
    data_t wdata;
    addr_t ra1;
    addr_t ra2;
    data_t exp1;
    data_t exp2;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input data_t act, input data_t exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {reset, wen, waddr, wdata, ra1, ra2, exp1, exp2}; expectations are read after the edge
    vecs[0]  = '{1'b1, 1'b1, 5'd18, 32'h0035_6423, 5'd18, 5'd0,  32'h0,          32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd18, 32'h0035_6423, 5'd18, 5'd0,  32'h0035_6423,  32'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd18, 32'h0,          32'h0035_6423};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  32'hA5A5_A5A5, 5'd5,  5'd5,  32'hA5A5_A5A5,  32'hA5A5_A5A5};
    vecs[4]  = '{1'b0, 1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd18, 32'hA5A5_A5A5,  32'h0035_6423};
    vecs[5]  = '{1'b0, 1'b1, 5'd31, 32'h1111_1111, 5'd31, 5'd5,  32'h1111_1111,  32'hA5A5_A5A5};
    vecs[6]  = '{1'b0, 1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001,  32'h1111_1111};
    vecs[7]  = '{1'b1, 1'b1, 5'd31, 32'h2222_2222, 5'd31, 5'd31, 32'h0,          32'h0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd18, 32'h0,          32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd0,  32'hCAFE_F00D,  32'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd13, 32'h8000_0000, 5'd12, 5'd13, 32'hCAFE_F00D,  32'h8000_0000};

    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Every address reads zero on both ports after reset
    for (int a = 0; a < 32; a++) begin
      ra1 = addr_t'(a);
      ra2 = addr_t'(31 - a);
      #1;
      check($sformatf("reset_rd1[%0d]", a), rd1, 32'h0);
      check($sformatf("reset_rd2[%0d]", 31 - a), rd2, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].reset; wen = vecs[i].wen; waddr = vecs[i].waddr;
      wdata = vecs[i].wdata; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      tick();
      reset = 1'b0; wen = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
    end

    // Same-cycle write/read of reg 7 (currently 0)
    wen = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; ra1 = 5'd7; ra2 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_pre_rd1", rd1, 32'hDEAD_BEEF);
    check("same_cycle_pre_rd2", rd2, 32'hDEAD_BEEF);
`else
    check("same_cycle_pre_rd1", rd1, 32'h0);
    check("same_cycle_pre_rd2", rd2, 32'h0);
`endif
    tick();
    check("same_cycle_post_rd1", rd1, 32'hDEAD_BEEF);
    check("same_cycle_post_rd2", rd2, 32'hDEAD_BEEF);

    // Write to x0 never forwards
    waddr = 5'd0; wdata = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd7;
    #1;
    check("x0_write_pre_rd1", rd1, 32'h0);
    check("x0_write_pre_rd2", rd2, 32'hDEAD_BEEF);

    // Write during reset: no forwarding, and discarded at the edge
    reset = 1'b1; waddr = 5'd7; wdata = 32'h5555_5555; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check("reset_write_pre_rd1", rd1, 32'hDEAD_BEEF);
    tick();
    reset = 1'b0; wen = 1'b0;
    #1;
    check("reset_write_post_rd1", rd1, 32'h0);
    check("reset_write_post_rd2", rd2, 32'h0);

    // Back-to-back writes to different registers, then read both
    wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    tick();
    waddr = 5'd4; wdata = 32'h0000_0044;
    tick();
    wen = 1'b0; ra1 = 5'd3; ra2 = 5'd4;
    #1;
    check("b2b_rd1", rd1, 32'h0000_0033);
    check("b2b_rd2", rd2, 32'h0000_0044);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W (32 registers).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rg_wrt_en  input  1  write enable.
REQ-006 rg_wrt_addr  input  ADDR_W  write register index.
REQ-007 rg_wrt_data  input  DATA_W  write data.
REQ-008 rg_rd_addr1  input  ADDR_W  read port 1 register index.
REQ-009 rg_rd_addr2  input  ADDR_W  read port 2 register index.
REQ-010 rg_rd_data1  output  DATA_W  read port 1 data.
REQ-011 rg_rd_data2  output  DATA_W  read port 2 data.

Function
REQ-012 The block SHALL hold 2**ADDR_W registers of DATA_W bits: two read ports, one write port.
REQ-013 Reads SHALL be combinational: rg_rd_dataN = reg[rg_rd_addrN] in the same cycle, zero latency.
REQ-014 On a rising clk edge with reset=0 and rg_wrt_en=1, reg[rg_wrt_addr] SHALL take rg_wrt_data.
REQ-015 With rg_wrt_en=0, no register SHALL change.
REQ-016 Register 0 SHALL read as 0 on both ports; writes to address 0 SHALL be ignored.
REQ-017 Without bypass (REQ-022), a written value SHALL appear on a read port only after the write edge; the read in the write cycle returns the old value.
REQ-018 Both ports reading the same address SHALL return identical data.
REQ-019 Reset SHALL take priority over a simultaneous write; a write asserted during reset is discarded.

Reset
REQ-020 On a rising clk edge with reset=1, all registers SHALL clear to 0; both read outputs are therefore 0 for any address from the following cycle.
REQ-021 Reset asserted mid-operation SHALL clear all state at that edge; no partial writes survive.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN defined: when rg_wrt_en=1, reset=0, rg_wrt_addr!=0 and rg_wrt_addr==rg_rd_addrN, rg_rd_dataN SHALL return rg_wrt_data combinationally (write-to-read forwarding). Undefined: no forwarding; REQ-017 applies.

Structure
REQ-023 Shared package reg_file_pkg SHALL hold DATA_W/ADDR_W defaults, the zero-register index constant and the data/address typedefs.
REQ-024 One sub-module, reg_file_rd_port, SHALL implement a single read port (array select, x0 forcing, optional bypass); it is instantiated twice.

Verification
REQ-025 reset=1, wrt_en=1, wrt_addr=18, wrt_data=0x00356423, rd_addr1=18, rd_addr2=0, one edge -> rd_data1=0, rd_data2=0.
REQ-026 Then reset=0, same write, one edge -> rd_data1=0x00356423, rd_data2=0.
REQ-027 wrt_en=1, wrt_addr=0, wrt_data=0xFFFFFFFF, edge; rd_addr1=0 -> rd_data1=0.
REQ-028 Write 0xA5A5A5A5 to reg 5, then wrt_en=0 with wrt_data=0x12345678, addr 5, edge -> reading reg 5 returns 0xA5A5A5A5.
REQ-029 Write 0x11111111 to reg 31, then reset=1, edge -> reading reg 31 on both ports returns 0.
REQ-030 Same-cycle write of 0xDEADBEEF to reg 7 with rd_addr1=7 -> before edge rd_data1 = old value (0) without REGFILE_BYPASS_EN, 0xDEADBEEF with it; after edge 0xDEADBEEF in both builds.
